// File: rtl/salsa_pkg.sv
// ---------------------------------------------------------------------------
// salsa_pkg : shared types, constants and quarterround helper for the Salsa20 core
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package salsa_pkg;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 16;

   localparam int ROT_A = 7;
   localparam int ROT_B = 9;
   localparam int ROT_C = 13;
   localparam int ROT_D = 18;

   typedef logic [NUM_WORDS-1:0][WORD_W-1:0] state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   // Each entry packs the word indices {a,b,c,d} of one quarterround, a in the top nibble.
   localparam logic [15:0] QR_COL [4] = '{16'h048C, 16'h59D1, 16'hAE26, 16'hF37B};
   localparam logic [15:0] QR_ROW [4] = '{16'h0123, 16'h5674, 16'hAB89, 16'hFCDE};

   function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int unsigned n);
      return (v << n) | (v >> (WORD_W - n));
   endfunction

   function automatic state_t quarter(input state_t s, input logic [15:0] idx);
      state_t     r;
      logic [3:0] a, b, c, d;
      a = idx[15:12];
      b = idx[11:8];
      c = idx[7:4];
      d = idx[3:0];
      r = s;
      r[b] = r[b] ^ rotl(r[a] + r[d], ROT_A);
      r[c] = r[c] ^ rotl(r[b] + r[a], ROT_B);
      r[d] = r[d] ^ rotl(r[c] + r[b], ROT_C);
      r[a] = r[a] ^ rotl(r[d] + r[c], ROT_D);
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/salsa_round_comb.sv
// ---------------------------------------------------------------------------
// salsa_round_comb : one combinational Salsa20 column or row round
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module salsa_round_comb
   import salsa_pkg::*;
(
   input  state_t words_in,
   input  logic   col_not_row,
   output state_t words_out
);

   // The four quarterrounds touch disjoint words, so applying them in sequence is exact.
   always_comb begin
      words_out = words_in;
      words_out = quarter(words_out, col_not_row ? QR_COL[0] : QR_ROW[0]);
      words_out = quarter(words_out, col_not_row ? QR_COL[1] : QR_ROW[1]);
      words_out = quarter(words_out, col_not_row ? QR_COL[2] : QR_ROW[2]);
      words_out = quarter(words_out, col_not_row ? QR_COL[3] : QR_ROW[3]);
   end

endmodule

`default_nettype wire

// File: rtl/salsa_core_param.sv
// ---------------------------------------------------------------------------
// salsa_core_param : handshaked Salsa20/R core computing Salsa(in_a ^ in_b)
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module salsa_core_param
   import salsa_pkg::*;
#(
   parameter int DOUBLE_ROUNDS    = 4,
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int FEED_FORWARD     = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [511:0] in_a,
   input  logic [511:0] in_b,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [511:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);

   localparam int         R        = 2 * DOUBLE_ROUNDS;
   localparam logic [5:0] LAST_CNT = 6'(R - ROUNDS_PER_CYCLE);
   localparam logic [5:0] CNT_STEP = 6'(ROUNDS_PER_CYCLE);

   if (DOUBLE_ROUNDS < 1 || DOUBLE_ROUNDS > 16 ||
       (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2)) begin : g_param_check
      $fatal(1, "salsa_core_param: illegal DOUBLE_ROUNDS or ROUNDS_PER_CYCLE");
   end

   fsm_t       fsm;
   logic [5:0] cnt;
   state_t     state;
   state_t     orig;
   state_t     sum;
   state_t     result;
   state_t     stage [ROUNDS_PER_CYCLE+1];

   assign stage[0] = state;

   // cnt always advances by ROUNDS_PER_CYCLE, so bit 0 plus the stage offset gives round parity.
   for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
      salsa_round_comb u_round (
         .words_in    (stage[g]),
         .col_not_row (~(cnt[0] ^ 1'(g))),
         .words_out   (stage[g+1])
      );
   end

   for (genvar i = 0; i < NUM_WORDS; i++) begin : g_ff
      assign sum[i] = stage[ROUNDS_PER_CYCLE][i] + orig[i];
   end

   assign result   = (FEED_FORWARD != 0) ? sum : stage[ROUNDS_PER_CYCLE];
   assign in_ready = (fsm == IDLE);
   assign busy     = (fsm != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm       <= IDLE;
         cnt       <= 6'd0;
         state     <= '0;
         orig      <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  state <= state_t'(in_a ^ in_b);
                  orig  <= state_t'(in_a ^ in_b);
                  cnt   <= 6'd0;
                  fsm   <= RUN;
               end
            end
            RUN: begin
               state <= stage[ROUNDS_PER_CYCLE];
               cnt   <= cnt + CNT_STEP;
               if (cnt == LAST_CNT) begin
                  out_data  <= result;
                  out_valid <= 1'b1;
                  fsm       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  fsm       <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
